// File: rtl/chain_manager.sv
// chain_manager: bump allocator that builds a singly linked chain of segments.
//   Each accepted request carves `size` words off the tail of a linear
//   address space and appends a new entry to the chain. Entries are never
//   freed; only reset clears the chain.
//
// Parameters
//   DEPTH      number of chain entries (2..8)
//   MEM_WORDS  size of the managed address space in words (1..65535)
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous active-high reset
//   request     allocation request, level sensitive (one request per edge)
//   size[7:0]   requested length in words
//   ack         one-cycle pulse after an accepted request
//   err         one-cycle pulse after a rejected request
//   alloc_idx   entry index of the last accepted allocation
//   alloc_base  base address of the last accepted allocation
//   count       number of valid chain entries
//   free_words  MEM_WORDS - tail (only when CHAIN_MANAGER_STATS_EN is defined)
//
// Entry layout (MSB..LSB): valid[28] last[27] next[26:24] size[23:16] base[15:0]
//
// Optional build macro: CHAIN_MANAGER_STATS_EN adds the free_words output.
module chain_manager #(
  parameter int DEPTH     = 6,
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic [7:0]  size,
  output logic        ack,
  output logic        err,
  output logic [2:0]  alloc_idx,
  output logic [15:0] alloc_base,
  output logic [3:0]  count
`ifdef CHAIN_MANAGER_STATS_EN
  ,
  output logic [15:0] free_words
`endif
);

  localparam logic [16:0] MEM_LIM = 17'(MEM_WORDS);
  localparam logic [3:0]  DEPTH_L = 4'(DEPTH);

  logic [28:0] chain [DEPTH];
  logic [15:0] tail;

  // Sum kept at 17 bits so a request near the top of a 64K space cannot wrap
  // and slip past the bound check.
  logic [16:0] end_addr;
  logic        size_zero;
  logic        full;
  logic        overflow;
  logic        accept;
  logic [28:0] new_entry;

  always_comb begin
    end_addr  = {1'b0, tail} + {9'b0, size};
    size_zero = (size == 8'd0);
    full      = (count >= DEPTH_L);
    overflow  = (end_addr > MEM_LIM);
    // Every reject reason yields the same err pulse, so the precedence
    // order only matters for readability here.
    accept    = request && !size_zero && !full && !overflow;
    new_entry = {1'b1, 1'b1, 3'd0, size, tail};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) chain[i] <= '0;
      tail       <= '0;
      count      <= '0;
      alloc_idx  <= '0;
      alloc_base <= '0;
      ack        <= 1'b0;
      err        <= 1'b0;
    end else begin
      ack <= accept;
      err <= request && !accept;
      if (accept) begin
        // Write the new tail entry and relink the previous tail in the same
        // edge; matching on count avoids a variable-width array index.
        for (int i = 0; i < DEPTH; i++) begin
          if (count == 4'(i)) begin
            chain[i] <= new_entry;
          end else if (count == 4'(i + 1)) begin
            chain[i][27]    <= 1'b0;
            chain[i][26:24] <= 3'(i + 1);
          end
        end
        tail       <= end_addr[15:0];
        count      <= count + 4'd1;
        alloc_idx  <= count[2:0];
        alloc_base <= tail;
      end
    end
  end

`ifdef CHAIN_MANAGER_STATS_EN
  assign free_words = 16'(MEM_WORDS) - tail;
`endif

endmodule

// File: tb/tb_chain_manager.sv
// Bench for chain_manager: a table of directed vectors, hand sequences for
// full / overflow / held request / mid-cycle reset, and a randomized run
// checked against a queue-based model of the allocator.
module tb_chain_manager;

  localparam int DEPTH = 6;
  localparam int MEM   = 1024;
  localparam int MEM_B = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        request = 1'b0;
  logic [7:0]  size = '0;
  logic        ack, err;
  logic [2:0]  alloc_idx;
  logic [15:0] alloc_base;
  logic [3:0]  count;

  logic        request_b = 1'b0;
  logic [7:0]  size_b = '0;
  logic        ack_b, err_b;
  logic [2:0]  alloc_idx_b;
  logic [15:0] alloc_base_b;
  logic [3:0]  count_b;
`ifdef CHAIN_MANAGER_STATS_EN
  logic [15:0] free_words, free_words_b;
`endif

  always #5 clk = ~clk;

  chain_manager #(.DEPTH(DEPTH), .MEM_WORDS(MEM)) dut (
    .clk(clk), .rst(rst), .request(request), .size(size),
    .ack(ack), .err(err), .alloc_idx(alloc_idx), .alloc_base(alloc_base),
    .count(count)
`ifdef CHAIN_MANAGER_STATS_EN
    , .free_words(free_words)
`endif
  );

  chain_manager #(.DEPTH(DEPTH), .MEM_WORDS(MEM_B)) dut_b (
    .clk(clk), .rst(rst), .request(request_b), .size(size_b),
    .ack(ack_b), .err(err_b), .alloc_idx(alloc_idx_b), .alloc_base(alloc_base_b),
    .count(count_b)
`ifdef CHAIN_MANAGER_STATS_EN
    , .free_words(free_words_b)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the chain is just the list of (base,size) handed out.
  int m_base[$];
  int m_size[$];
  int m_tail;
  int m_ack, m_err, m_idx, m_abase;

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_base.delete();
    m_size.delete();
    m_tail = 0; m_ack = 0; m_err = 0; m_idx = 0; m_abase = 0;
  endtask

  task automatic model_apply(bit r, int s);
    m_ack = 0;
    m_err = 0;
    if (r) begin
      if (s != 0 && m_size.size() < DEPTH && m_tail + s <= MEM) begin
        m_idx   = m_size.size();
        m_abase = m_tail;
        m_base.push_back(m_tail);
        m_size.push_back(s);
        m_tail += s;
        m_ack = 1;
      end else begin
        m_err = 1;
      end
    end
  endtask

  function automatic logic [28:0] exp_entry(int i);
    logic lst;
    if (i >= m_size.size()) return '0;
    lst = (i == m_size.size() - 1);
    return {1'b1, lst, lst ? 3'd0 : 3'(i + 1), 8'(m_size[i]), 16'(m_base[i])};
  endfunction

  task automatic check_model(string tag);
    cmp({tag, " ack"}, 32'(ack), 32'(m_ack));
    cmp({tag, " err"}, 32'(err), 32'(m_err));
    cmp({tag, " alloc_idx"}, 32'(alloc_idx), 32'(m_idx));
    cmp({tag, " alloc_base"}, 32'(alloc_base), 32'(m_abase));
    cmp({tag, " count"}, 32'(count), 32'(m_size.size()));
    cmp({tag, " tail"}, 32'(dut.tail), 32'(m_tail));
    for (int i = 0; i < DEPTH; i++)
      cmp($sformatf("%s chain[%0d]", tag, i), 32'(dut.chain[i]), 32'(exp_entry(i)));
`ifdef CHAIN_MANAGER_STATS_EN
    cmp({tag, " free_words"}, 32'(free_words), 32'(MEM - m_tail));
`endif
  endtask

  // One clock: drive on the falling edge, check 1 time unit after the rise.
  task automatic step(bit r, logic [7:0] s);
    @(negedge clk);
    request = r;
    size    = s;
    @(posedge clk);
    #1;
    model_apply(r, int'(s));
    check_model("step");
  endtask

  // Reset asserted mid-cycle with a live request, held across one edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    request = 1'b1;
    size = 8'd4;
    model_clear();
    #1;
    check_model("rst_async");
    @(posedge clk);
    #1;
    check_model("rst_edge");
    @(negedge clk);
    rst = 1'b0;
    request = 1'b0;
  endtask

  typedef struct {
    bit       req;
    bit [7:0] sz;
    bit       ack;
    bit       err;
    int       idx;
    int       base;
    int       cnt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 8'd16, 1'b1, 1'b0, 0, 0,  1};
    tbl[1] = '{1'b0, 8'd0,  1'b0, 1'b0, 0, 0,  1};
    tbl[2] = '{1'b1, 8'd32, 1'b1, 1'b0, 1, 16, 2};
    tbl[3] = '{1'b0, 8'd0,  1'b0, 1'b0, 1, 16, 2};
    tbl[4] = '{1'b1, 8'd64, 1'b1, 1'b0, 2, 48, 3};
    tbl[5] = '{1'b0, 8'd0,  1'b0, 1'b0, 2, 48, 3};
    tbl[6] = '{1'b1, 8'd0,  1'b0, 1'b1, 2, 48, 3};

    model_clear();
    do_reset();

    // Directed table: three allocations then a zero-size reject.
    for (int v = 0; v < 7; v++) begin
      step(tbl[v].req, tbl[v].sz);
      cmp($sformatf("tbl%0d ack", v), 32'(ack), 32'(tbl[v].ack));
      cmp($sformatf("tbl%0d err", v), 32'(err), 32'(tbl[v].err));
      cmp($sformatf("tbl%0d idx", v), 32'(alloc_idx), 32'(tbl[v].idx));
      cmp($sformatf("tbl%0d base", v), 32'(alloc_base), 32'(tbl[v].base));
      cmp($sformatf("tbl%0d count", v), 32'(count), 32'(tbl[v].cnt));
    end
    cmp("tbl chain0", 32'(dut.chain[0]), 32'({1'b1, 1'b0, 3'd1, 8'd16, 16'd0}));
    cmp("tbl chain1", 32'(dut.chain[1]), 32'({1'b1, 1'b0, 3'd2, 8'd32, 16'd16}));
    cmp("tbl chain2", 32'(dut.chain[2]), 32'({1'b1, 1'b1, 3'd0, 8'd64, 16'd48}));
    step(1'b0, 8'd0);

    // Fill to DEPTH with size-1 requests; the seventh is rejected.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 8'd1);
      cmp($sformatf("full ack%0d", i), 32'(ack), (i < 6) ? 32'd1 : 32'd0);
      cmp($sformatf("full err%0d", i), 32'(err), (i == 6) ? 32'd1 : 32'd0);
      cmp($sformatf("full idx%0d", i), 32'(alloc_idx), (i < 6) ? 32'(i) : 32'd5);
    end
    cmp("full chain5 last", 32'(dut.chain[5][27]), 32'd1);
    step(1'b0, 8'd0);

    // Request held high three cycles.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'd8);
      cmp($sformatf("held ack%0d", i), 32'(ack), 32'd1);
      cmp($sformatf("held base%0d", i), 32'(alloc_base), 32'(i * 8));
    end

    // Two allocations then reset mid-cycle; first allocation after reset.
    step(1'b0, 8'd0);
    do_reset();
    step(1'b1, 8'd10);
    step(1'b1, 8'd20);
    do_reset();
    cmp("rst count", 32'(count), 32'd0);
    step(1'b1, 8'd4);
    cmp("post rst ack", 32'(ack), 32'd1);
    cmp("post rst idx", 32'(alloc_idx), 32'd0);
    cmp("post rst base", 32'(alloc_base), 32'd0);
`ifdef CHAIN_MANAGER_STATS_EN
    cmp("post rst free_words", 32'(free_words), 32'(MEM - 4));
`endif
    step(1'b0, 8'd0);

    // Small address space on the second instance: overflow and exact fit.
    do_reset();
    begin
      int sz_b[4]  = '{64, 40, 36, 1};
      int ack_e[4] = '{1, 0, 1, 0};
      int bas_e[4] = '{0, 0, 64, 64};
      int tl_e[4]  = '{64, 64, 100, 100};
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        request_b = 1'b1;
        size_b = 8'(sz_b[i]);
        @(posedge clk);
        #1;
        cmp($sformatf("mem100 ack%0d", i), 32'(ack_b), 32'(ack_e[i]));
        cmp($sformatf("mem100 err%0d", i), 32'(err_b), 32'(1 - ack_e[i]));
        cmp($sformatf("mem100 base%0d", i), 32'(alloc_base_b), 32'(bas_e[i]));
        cmp($sformatf("mem100 tail%0d", i), 32'(dut_b.tail), 32'(tl_e[i]));
      end
      @(negedge clk);
      request_b = 1'b0;
      @(posedge clk);
      #1;
      cmp("mem100 idle ack", 32'(ack_b), 32'd0);
      cmp("mem100 idle err", 32'(err_b), 32'd0);
      cmp("mem100 count", 32'(count_b), 32'd2);
`ifdef CHAIN_MANAGER_STATS_EN
      cmp("mem100 free_words", 32'(free_words_b), 32'd0);
`endif
    end

    // Randomized run against the model, with occasional resets.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int pick;
      logic [7:0] s;
      pick = int'($urandom_range(0, 99));
      if (pick < 2) begin
        do_reset();
      end else begin
        if (pick < 10) s = 8'd0;
        else s = 8'($urandom_range(1, 255));
        step(pick < 65, s);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
